// File: rtl/fullAdd.sv
// Single-bit full adder from the projectALU library; purely combinational.
module fullAdd (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic out,
    output logic Cout
);
    assign out  = a ^ b ^ Cin;
    assign Cout = (a & b) | (a & Cin) | (b & Cin);
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial add/subtract sequencer: walks one fullAdd over a WIDTH-bit operand
// pair LSB first, with a registered carry and a start/busy/done handshake.
module serial_alu_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sa_reg, sb_reg, res_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg, cmsb_reg;
    logic               cout_reg, ovf_reg, zero_reg;
    logic               fa_out, fa_cout;
    logic               last_bit;
    logic [WIDTH-1:0]   final_res;

    fullAdd u_fa (
        .a    (sa_reg[0]),
        .b    (sb_reg[0]),
        .Cin  (carry_reg),
        .out  (fa_out),
        .Cout (fa_cout)
    );

    assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));
    assign final_res = {fa_out, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_reg     <= '0;
            sb_reg     <= '0;
            res_reg    <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            cmsb_reg   <= 1'b0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry with op.
                        sa_reg    <= opa;
                        sb_reg    <= op ? ~opb : opb;
                        carry_reg <= op;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    sa_reg    <= sa_reg >> 1;
                    sb_reg    <= sb_reg >> 1;
                    res_reg   <= final_res;
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 2))
                        cmsb_reg <= fa_cout;
                    // Outputs only change here, so partial sums never leak out.
                    if (last_bit) begin
                        result_reg <= final_res;
                        cout_reg   <= fa_cout;
                        ovf_reg    <= cmsb_reg ^ fa_cout;
                        zero_reg   <= (final_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;
    assign zero   = zero_reg;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl (WIDTH=8) with hand-computed expectations.
module tb_serial_alu_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, op;
    logic [W-1:0] opa, opb;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // inj: RUN cycle in which a stray start (0xFF, subtract) is pulsed; rstc: RUN cycle with rst high.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic o, input int inj, input int rstc,
                          input logic [W-1:0] er, input logic ec, input logic eo, input logic ez);
        bit aborted;
        aborted = 0;
        start = 1'b1; opa = a; opb = b; op = o;
        tick();
        start = 1'b0; opa = ~a; opb = ~b; op = ~o;
        check({tag, " busy@accept"}, W'(busy), W'(1));
        for (int k = 1; k < W && !aborted; k++) begin
            if (k == inj) begin start = 1'b1; opa = 8'hFF; op = 1'b1; end
            if (k == rstc) rst = 1'b1;
            tick();
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                aborted = 1;
                check({tag, " rst busy"}, W'(busy), W'(0));
                check({tag, " rst done"}, W'(done), W'(0));
                check({tag, " rst result"}, result, W'(0));
                check({tag, " rst flags"}, W'({cout, ovf, zero}), W'(0));
                for (int j = 0; j < W + 2; j++) begin
                    tick();
                    check({tag, " no done after rst"}, W'(done), W'(0));
                end
            end else begin
                check({tag, " done low"}, W'(done), W'(0));
                check({tag, " busy high"}, W'(busy), W'(1));
            end
        end
        if (!aborted) begin
            tick();
            check({tag, " done"}, W'(done), W'(1));
            check({tag, " result"}, result, er);
            check({tag, " cout"}, W'(cout), W'(ec));
            check({tag, " ovf"}, W'(ovf), W'(eo));
            check({tag, " zero"}, W'(zero), W'(ez));
            tick();
            check({tag, " done one cycle"}, W'(done), W'(0));
            check({tag, " idle"}, W'(busy), W'(0));
            check({tag, " result held"}, result, er);
            $display("%s: opa=%h opb=%h op=%0d -> result=%h cout=%0d ovf=%0d zero=%0d",
                     tag, a, b, o, result, cout, ovf, zero);
        end else begin
            $display("%s: aborted by reset in RUN cycle %0d", tag, rstc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", result, W'(0));
        check("reset flags", W'({cout, ovf, zero}), W'(0));
        tick();

        run_op("add 5A+33", 8'h5A, 8'h33, 1'b0, 0, 0, 8'h8D, 1'b0, 1'b1, 1'b0);
        // Issued on the first IDLE cycle after done: back-to-back accept.
        run_op("add FF+01", 8'hFF, 8'h01, 1'b0, 0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub 10-20", 8'h10, 8'h20, 1'b1, 0, 0, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op("sub 80-01", 8'h80, 8'h01, 1'b1, 0, 0, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("add 01+01 stray start", 8'h01, 8'h01, 1'b0, 3, 0, 8'h02, 1'b0, 1'b0, 1'b0);
        tick();
        check("stray start not queued", W'(busy), W'(0));
        run_op("add 5A+33 reset", 8'h5A, 8'h33, 1'b0, 0, 4, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op("add 7F+01", 8'h7F, 8'h01, 1'b0, 0, 0, 8'h80, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
